sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

Sequential SHA-256 message-schedule stage. Accepts one padded 512-bit message block from the padder and emits the 64 schedule words W0..W63, one per handshake, to the round/compression stage. A 16-word sliding window computes each new word, so the stage needs no 64-entry store. Valid/ready handshakes on both sides let the compression stage stall it freely.

## Interface

Parameters:
- none; word width (32), window depth (16) and round count (64) are fixed by FIPS 180-4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- block_valid  input  1  padded block available on `block`
- block  input  512  padded block; M0 = block[511:480], M15 = block[31:0]
- block_ready  output  1  stage idle and able to accept a block
- w_valid  output  1  `w` holds a valid schedule word
- w_ready  input  1  downstream accepts `w` this cycle
- w  output  32  schedule word Wt
- t  output  6  round index of `w` (0..63)
- w_last  output  1  high when `w_valid` and t == 63

## Operation

- Two states: IDLE and RUN.
- IDLE:
  - block_ready = 1, w_valid = 0.
  - On block_valid && block_ready, load window[0..15] = M0..M15, t = 0, go to RUN.
- RUN:
  - block_ready = 0, w_valid = 1, w = window[0], w_last = (t == 63).
  - On w_valid && w_ready (accept):
    - window[i] <= window[i+1] for i = 0..14.
    - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
    - t <= t + 1.
  - An accept with t == 63 goes to IDLE; the window contents are then don't-care.
  - Without an accept, window, t and w hold (stall).
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- All additions are 32-bit wrap-around; carries are discarded.
- Words computed while t ≥ 48 (W64..W79) are never presented; computing them is harmless.
- block_valid is ignored in RUN. The upstream stage holds `block` until it sees block_ready.
- w, t and w_last are registered or derived from state; there is no combinational path from any input to w_valid or w.

## Timing

- Reset values (asynchronous, take effect immediately):
  - state = IDLE, block_ready = 1, w_valid = 0, w_last = 0.
  - w = 0, t = 0, window = 0.
- Load latency: a block accepted at edge N gives w_valid = 1 with w = M0, t = 0 after edge N.
- Throughput: one word per cycle while w_ready = 1, so 64 cycles per block.
- Back-to-back blocks:
  - block_ready returns to 1 in the cycle after the accept of W63.
  - Minimum block-to-block spacing is 65 cycles, with exactly one bubble cycle (w_valid = 0).
- Stall: w_ready = 0 for any number of cycles holds w, t and w_last unchanged.
- Reset asserted mid-block: the block is abandoned and all outputs go to their reset values at once. After release, the next block_valid is accepted normally.
- block_valid and w_ready arriving in the same cycle interact only through state, since IDLE and RUN are exclusive.

## Test plan

- Reset: assert reset mid-RUN at t = 20 → w_valid = 0, block_ready = 1, t = 0 immediately. A following block restarts at t = 0 with w = M0.
- "abc" block (0x61626380, zeros, final word 0x00000018), w_ready held 1:
  - W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405.
  - W19..W63 match the software model.
  - w_last = 1 only with t = 63.
  - Exactly 64 accepts, then block_ready = 1.
- All-zero block → W0..W63 all 0x00000000, and w_last fires once.
- Stall: pseudo-random w_ready (~50% duty) on the "abc" block → same 64-word sequence in order, w stable during every stall, no word skipped or repeated.
- Back-to-back: block_valid held 1 with two different blocks queued, w_ready = 1:
  - Second block accepted the cycle after W63 of the first.
  - Exactly one w_valid = 0 cycle between the two streams.
  - Second block's W0 equals its M0.
- block_valid pulsed during RUN with different data → ignored; the current stream is unchanged.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Sequential SHA-256 message schedule. Loads one padded 512-bit block and
//   streams W0..W63 over a valid/ready handshake. Each new word is produced
//   from a 16-word sliding window, so no 64-entry store is needed.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   block_valid  padded block present on `block`
//   block        512-bit block, M0 = block[511:480] ... M15 = block[31:0]
//   block_ready  idle, a block is taken on block_valid
//   w_valid      `w` holds schedule word Wt
//   w_ready      downstream takes `w` this cycle
//   w            schedule word Wt
//   t            round index of `w` (0..63)
//   w_last       w_valid and t == 63
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         reset,
    input  logic         block_valid,
    input  logic [511:0] block,
    output logic         block_ready,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w,
    output logic [5:0]   t,
    output logic         w_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [15:0][31:0]  window;   // window[0] is the word currently presented
    logic [31:0]        w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Window positions map to W[t+i]; the recurrence W[t+16] uses
    // W[t+14], W[t+9], W[t+1], W[t].
    always_comb begin
        w_next = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            window <= '0;
            t      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (block_valid) begin
                        for (int i = 0; i < 16; i++)
                            window[i] <= block[511 - 32*i -: 32];
                        t     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        for (int i = 0; i < 15; i++)
                            window[i] <= window[i+1];
                        // Words past W63 are computed but never presented.
                        window[15] <= w_next;
                        t          <= t + 6'd1;
                        if (t == 6'd63)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers; no input reaches w_valid or w.
    assign block_ready = (state == IDLE);
    assign w_valid     = (state == RUN);
    assign w           = window[0];
    assign w_last      = w_valid && (t == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: a FIPS-style reference model fills a queue
// of expected (w, t) pairs when a block is loaded; words are popped and
// compared as the DUT hands them over.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         block_valid;
    logic [511:0] block;
    logic         block_ready;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w;
    logic [5:0]   t;
    logic         w_last;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  t;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    sha256_msg_schedule dut (
        .clk         (clk),
        .reset       (reset),
        .block_valid (block_valid),
        .block       (block),
        .block_ready (block_ready),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w           (w),
        .t           (t),
        .w_last      (w_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic void push_block(input logic [511:0] b);
        logic [31:0] wv [64];
        for (int i = 0; i < 16; i++) wv[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            wv[i] = s1(wv[i-2]) + wv[i-7] + s0(wv[i-15]) + wv[i-16];
        for (int i = 0; i < 64; i++) begin
            exp_t e;
            e.w = wv[i];
            e.t = 6'(i);
            exp_q.push_back(e);
        end
    endfunction

    // Advance one cycle; we always sit at the falling edge between steps.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [511:0] b);
        chk("load_ready", block_ready, 1'b1);
        block       = b;
        block_valid = 1'b1;
        push_block(b);
        step();
        block_valid = 1'b0;
    endtask

    // Consume n words. rnd: random w_ready; noise: random block_valid/data
    // while running; kat: also check the published "abc" schedule words.
    task automatic drain(input int n, input bit rnd, input bit noise, input bit kat);
        int   got = 0;
        int   cyc = 0;
        exp_t e;
        while (got < n && cyc < 2000) begin
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                block_valid = 1'($urandom_range(0, 1));
                for (int i = 0; i < 16; i++) block[32*i +: 32] = $urandom;
            end
            if (w_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 1'b1, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("w", w, e.w);
                    chk("t", t, e.t);
                    chk("w_last", w_last, e.t == 6'd63);
                    chk("block_ready_run", block_ready, 1'b0);
                    if (kat && w_ready) begin
                        case (e.t)
                            6'd0:  chk("kat_w0",  w, 32'h61626380);
                            6'd15: chk("kat_w15", w, 32'h00000018);
                            6'd16: chk("kat_w16", w, 32'h61626380);
                            6'd17: chk("kat_w17", w, 32'h000F0000);
                            6'd18: chk("kat_w18", w, 32'h7DA86405);
                            default: ;
                        endcase
                    end
                    if (w_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            step();
            cyc++;
        end
        if (noise) block_valid = 1'b0;
        w_ready = 1'b0;
        if (got < n) chk("timeout", 64'(got), 64'(n));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ready"}, block_ready, 1'b1);
        chk({tag, "_valid"}, w_valid, 1'b0);
        chk({tag, "_last"},  w_last, 1'b0);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    logic [511:0] abc_blk;
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    initial begin
        abc_blk      = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        reset       = 1'b1;
        block_valid = 1'b0;
        w_ready     = 1'b0;
        block       = '0;

        // Reset state
        @(negedge clk);
        idle_chk("rst");
        chk("rst_w", w, 32'h0);
        chk("rst_t", t, 6'h0);
        reset = 1'b0;
        @(negedge clk);

        // "abc" block, w_ready held high
        load(abc_blk);
        drain(64, 1'b0, 1'b0, 1'b1);
        idle_chk("abc_end");

        // All-zero block
        load('0);
        drain(64, 1'b0, 1'b0, 1'b0);
        idle_chk("zero_end");

        // "abc" with random stalls and block_valid noise during RUN
        load(abc_blk);
        drain(64, 1'b1, 1'b1, 1'b1);
        idle_chk("stall_end");

        // Reset mid-block at t = 20
        load(rand_block());
        drain(20, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_t", t, 6'd20);
        reset = 1'b1;
        #1;
        idle_chk("mid_rst");
        chk("mid_rst_t", t, 6'h0);
        chk("mid_rst_w", w, 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        load(rand_block());
        drain(64, 1'b0, 1'b0, 1'b0);
        idle_chk("post_rst_end");

        // Back-to-back: block_valid stays high, B queued behind A
        blk_a = rand_block();
        blk_b = rand_block();
        load(blk_a);
        block       = blk_b;
        block_valid = 1'b1;
        drain(64, 1'b0, 1'b0, 1'b0);
        idle_chk("b2b_bubble");
        push_block(blk_b);
        step();
        block_valid = 1'b0;
        chk("b2b_valid", w_valid, 1'b1);
        chk("b2b_t0", t, 6'd0);
        chk("b2b_m0", w, {32'h0, blk_b[511:480]});
        drain(64, 1'b0, 1'b0, 1'b0);
        idle_chk("b2b_end");
        chk("sb_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
